// File: rtl/core_rf_pkg.sv
// core_rf_pkg: shared register-file types and constants.
//   XLEN/NREG are the default data width and register count, idxw() derives
//   the index width, wb_req_t bundles one writeback request, and RESET_SP is
//   the stack-pointer reset value (taken from RESET_VECTOR when the build defines it).
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h8000_0000
`endif
package core_rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  function automatic int idxw(input int n);
    return $clog2(n);
  endfunction
  localparam int IDXW = idxw(NREG);
  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] data;
  } wb_req_t;
  localparam logic [XLEN-1:0] RESET_SP = `RESET_VECTOR;
endpackage

// File: rtl/gpr_sb_rf_if.sv
// gpr_sb_rf_if: decode/issue/writeback bus of the scoreboarded register file.
//   master: pipeline side (drives indices, issue, writebacks, flush).
//   slave:  register file side (drives read data, busy, ready, busy_vec).
interface gpr_sb_rf_if
  import core_rf_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWB = 2
) ();
  logic [NRD*IDXW-1:0] rd_idx;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [IDXW-1:0]     iss_rd;
  logic                iss_ready;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*IDXW-1:0] wb_idx;
  logic [NWB*XLEN-1:0] wb_data;
  logic [NWB-1:0]      wb_ready;
  logic [NREG-1:0]     busy_vec;
  logic                flush;
  modport master (
    output rd_idx, iss_valid, iss_rd, wb_valid, wb_idx, wb_data, flush,
    input  rd_data, rd_busy, iss_ready, wb_ready, busy_vec
  );
  modport slave (
    input  rd_idx, iss_valid, iss_rd, wb_valid, wb_idx, wb_data, flush,
    output rd_data, rd_busy, iss_ready, wb_ready, busy_vec
  );
endinterface

// File: rtl/gpr_sb_wb_arb.sv
// gpr_sb_wb_arb: writeback port arbitration.
//   valid/idx in per port; ready[k] drops when a lower port is valid for the
//   same nonzero index (independent of valid[k]); we = valid & ready.
module gpr_sb_wb_arb #(
  parameter int NWB  = 2,
  parameter int IDXW = 5
) (
  input  logic [NWB-1:0]      valid,
  input  logic [NWB*IDXW-1:0] idx,
  output logic [NWB-1:0]      ready,
  output logic [NWB-1:0]      we
);
  always_comb begin
    ready = '1;
    for (int k = 1; k < NWB; k++)
      for (int j = 0; j < k; j++)
        if (valid[j] && idx[j*IDXW +: IDXW] == idx[k*IDXW +: IDXW] && idx[k*IDXW +: IDXW] != '0)
          ready[k] = 1'b0;
  end
  assign we = valid & ready;
endmodule

// File: rtl/gpr_sb_rf.sv
// gpr_sb_rf: multi-port integer register file with scoreboard busy bits.
//   clk, rstn (async active-low) plain ports; everything else on bus (slave):
//   combinational reads with busy status, rd reservation on issue, prioritised
//   writeback ports that retire results, flush clears all busy bits.
//   x0 reads zero, is never busy and ignores writes.
//   GPR_SB_BYPASS_EN: reads forward same-cycle accepted writeback data.
module gpr_sb_rf #(
  parameter int                          XLEN     = core_rf_pkg::XLEN,
  parameter int                          NREG     = core_rf_pkg::NREG,
  parameter int                          NRD      = 2,
  parameter int                          NWB      = 2,
  parameter int                          SP_IDX   = 2,
  parameter logic [core_rf_pkg::XLEN-1:0] RESET_SP = core_rf_pkg::RESET_SP
) (
  input logic         clk,
  input logic         rstn,
  gpr_sb_rf_if.slave  bus
);
  import core_rf_pkg::*;
  localparam int IDXW = idxw(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NWB-1:0]  wb_we;
  logic            iss_fire;
  gpr_sb_wb_arb #(.NWB(NWB), .IDXW(IDXW)) u_arb (
    .valid (bus.wb_valid),
    .idx   (bus.wb_idx),
    .ready (bus.wb_ready),
    .we    (wb_we)
  );
  assign bus.iss_ready = !busy[bus.iss_rd] || bus.iss_rd == '0;
  assign iss_fire      = bus.iss_valid && bus.iss_ready && !bus.flush && bus.iss_rd != '0;
  assign bus.busy_vec  = busy;
  // Later assignments win: issue re-reserves over a same-cycle writeback clear,
  // and flush overrides both. regs[0] is never written so it stays zero.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) regs[r] <= (r == SP_IDX) ? RESET_SP : '0;
      busy <= '0;
    end else begin
      for (int k = NWB-1; k >= 0; k--)
        if (wb_we[k] && bus.wb_idx[k*IDXW +: IDXW] != '0) begin
          regs[bus.wb_idx[k*IDXW +: IDXW]] <= bus.wb_data[k*XLEN +: XLEN];
          busy[bus.wb_idx[k*IDXW +: IDXW]] <= 1'b0;
        end
      if (iss_fire) busy[bus.iss_rd] <= 1'b1;
      if (bus.flush) busy <= '0;
    end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDXW-1:0] ri;
    logic [XLEN-1:0] d;
    logic            b;
    assign ri = bus.rd_idx[p*IDXW +: IDXW];
`ifdef GPR_SB_BYPASS_EN
    // Descending scan so the lowest accepted port wins; a same-cycle issue to
    // this index suppresses forwarding because the register gets a new owner.
    always_comb begin
      d = regs[ri];
      b = busy[ri];
      for (int k = NWB-1; k >= 0; k--)
        if (wb_we[k] && ri != '0 && bus.wb_idx[k*IDXW +: IDXW] == ri && !(iss_fire && bus.iss_rd == ri)) begin
          d = bus.wb_data[k*XLEN +: XLEN];
          b = 1'b0;
        end
    end
`else
    assign d = regs[ri];
    assign b = busy[ri];
`endif
    assign bus.rd_data[p*XLEN +: XLEN] = d;
    assign bus.rd_busy[p] = b;
  end
endmodule
